spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Shares one synchronous RAM port between a non-stallable SPI slave and a CPU,
// parking SPI writes in a one-entry aged write buffer with read forwarding.
module spi_mem_arbiter #(
    parameter int AW     = 16,
    parameter int WB_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   spi_addr,
    input  logic          spi_en,
    input  logic          spi_wr,
    input  logic [7:0]    spi_wdata,
    output logic [7:0]    spi_rdata,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_en,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_rdy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          wb_overrun
);
    localparam int AGE_W = (WB_MAX > 1) ? $clog2(WB_MAX) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WB_MAX - 1);

    typedef enum logic [1:0] {G_NONE, G_SPI_RD, G_WB, G_CPU} grant_t;
    typedef enum logic [2:0] {O_NONE, O_SPI_RD, O_CPU, O_FWD_SPI, O_FWD_CPU, O_OOR} owner_t;

    grant_t          grant;
    owner_t          owner, next_owner;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [7:0]      wb_data;
    logic [AGE_W-1:0] wb_age;
    logic [7:0]      fwd_data;

    logic spi_in_range, spi_rd_req, spi_wr_hit, wb_forced, spi_fwd, cpu_fwd;

    assign spi_in_range = (spi_addr[23:AW] == '0);
    assign spi_rd_req   = spi_en & ~spi_wr;
    assign spi_wr_hit   = spi_en & spi_wr & spi_in_range;
    assign wb_forced    = wb_valid & (wb_age == AGE_MAX);
    assign spi_fwd      = wb_valid & (wb_addr == spi_addr[AW-1:0]);
    assign cpu_fwd      = wb_valid & (wb_addr == cpu_addr);

    // Any SPI read strobe takes the slot, even out of range, so its 0xFF
    // result never competes with a CPU read for the single owner register.
    always_comb begin
        grant = G_NONE;
        if (rst)
            grant = G_NONE;
        else if (spi_rd_req)
            grant = G_SPI_RD;
        else if (wb_valid && (wb_forced || spi_wr_hit))
            grant = G_WB;
        else if (cpu_en)
            grant = G_CPU;
        else if (wb_valid)
            grant = G_WB;
    end

    always_comb begin
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        next_owner = O_NONE;
        case (grant)
            G_SPI_RD: begin
                ram_addr = spi_addr[AW-1:0];
                if (spi_in_range) begin
                    ram_en     = 1'b1;
                    next_owner = spi_fwd ? O_FWD_SPI : O_SPI_RD;
                end else begin
                    next_owner = O_OOR;
                end
            end
            G_WB: begin
                ram_en    = 1'b1;
                ram_wr    = 1'b1;
                ram_addr  = wb_addr;
                ram_wdata = wb_data;
            end
            G_CPU: begin
                ram_en    = 1'b1;
                ram_wr    = cpu_wr;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                if (!cpu_wr)
                    next_owner = cpu_fwd ? O_FWD_CPU : O_CPU;
            end
            default: ;
        endcase
    end

    assign cpu_rdy = ~cpu_en | (grant == G_CPU);

    // Read results land one edge after the RAM data appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= O_NONE;
            fwd_data  <= '0;
            spi_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            owner    <= next_owner;
            fwd_data <= wb_data;
            case (owner)
                O_SPI_RD:  spi_rdata <= ram_rdata;
                O_FWD_SPI: spi_rdata <= fwd_data;
                O_OOR:     spi_rdata <= 8'hFF;
                O_CPU:     cpu_rdata <= ram_rdata;
                O_FWD_CPU: cpu_rdata <= fwd_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_age     <= '0;
            wb_overrun <= 1'b0;
        end else if (spi_wr_hit) begin
            wb_valid <= 1'b1;
            wb_addr  <= spi_addr[AW-1:0];
            wb_data  <= spi_wdata;
            wb_age   <= '0;
            if (wb_valid)
                wb_overrun <= 1'b1;
        end else if (grant == G_WB) begin
            wb_valid <= 1'b0;
            wb_age   <= '0;
        end else if (grant == G_CPU && cpu_wr && cpu_fwd) begin
            // The CPU write supersedes the buffered byte, so it is dropped.
            wb_valid <= 1'b0;
            wb_age   <= '0;
        end else if (wb_valid && wb_age != AGE_MAX) begin
            wb_age <= wb_age + AGE_W'(1);
        end
    end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_spi_mem_arbiter;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic [23:0]   spi_addr;
    logic          spi_en;
    logic          spi_wr;
    logic [7:0]    spi_wdata;
    logic [7:0]    spi_rdata;
    logic [AW-1:0] cpu_addr;
    logic          cpu_en;
    logic          cpu_wr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_rdy;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_wr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          wb_overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ram_wr = 0;
    int wr_snap;
    logic [4:0] rdy_exp;
    logic [7:0] mem [int];

    spi_mem_arbiter #(.AW(AW), .WB_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .spi_addr(spi_addr), .spi_en(spi_en), .spi_wr(spi_wr),
        .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_wr(ram_wr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wb_overrun(wb_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back as addr[7:0] ^ 0x7C (0x0040 -> 0x3C).
    function automatic logic [7:0] ram_peek(input logic [15:0] a);
        if (mem.exists(int'(a)))
            return mem[int'(a)];
        return a[7:0] ^ 8'h7C;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) begin
                mem[int'(ram_addr)] = ram_wdata;
                n_ram_wr = n_ram_wr + 1;
            end else begin
                ram_rdata <= ram_peek(ram_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic idle();
        spi_en = 1'b0; spi_wr = 1'b0; spi_addr = '0; spi_wdata = '0;
        cpu_en = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic spi_write(input logic [23:0] a, input logic [7:0] d);
        spi_en = 1'b1; spi_wr = 1'b1; spi_addr = a; spi_wdata = d;
    endtask

    task automatic spi_read(input logic [23:0] a);
        spi_en = 1'b1; spi_wr = 1'b0; spi_addr = a;
    endtask

    task automatic cpu_req(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_en = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram_rdata = '0;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_spi_rdata", spi_rdata, 8'h00);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_overrun", wb_overrun, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_cpu_rdy", cpu_rdy, 1'b1);
        rst = 1'b0;
        tick();

        // Buffered write drains on the following idle cycle.
        idle(); spi_write(24'h000123, 8'hA5); #1;
        check("t1_capture_no_ram", ram_en, 1'b0);
        tick();
        idle(); #1;
        check("t1_wb_en_wr", {ram_en, ram_wr}, 2'b11);
        check("t1_wb_addr", ram_addr, 16'h0123);
        check("t1_wb_data", ram_wdata, 8'hA5);
        tick();
        check("t1_ram", ram_peek(16'h0123), 8'hA5);

        // Continuous CPU reads: buffer forced out when its age reaches 3.
        idle(); spi_write(24'h000300, 8'h5A); cpu_req(1'b0, 16'h0200, 8'h00); #1;
        check("t2_rdy_c0", cpu_rdy, 1'b1);
        tick();
        rdy_exp = 5'b10111;
        for (int i = 0; i < 5; i++) begin
            idle(); cpu_req(1'b0, 16'h0201, 8'h00); #1;
            check($sformatf("t2_rdy_c%0d", i + 1), cpu_rdy, rdy_exp[i]);
            if (i == 3)
                check("t2_forced_addr", ram_addr, 16'h0300);
            tick();
        end
        idle(); #1;
        tick();
        check("t2_ram", ram_peek(16'h0300), 8'h5A);
        check("t2_cpu_rdata", cpu_rdata, 8'h7D);

        // SPI read pre-empts a pending CPU read.
        idle(); spi_read(24'h000040); cpu_req(1'b0, 16'h0200, 8'h00); #1;
        check("t3_cpu_blocked", cpu_rdy, 1'b0);
        check("t3_ram_en", ram_en, 1'b1);
        check("t3_ram_addr", ram_addr, 16'h0040);
        tick();
        idle(); cpu_req(1'b0, 16'h0200, 8'h00); #1;
        check("t3_cpu_granted", cpu_rdy, 1'b1);
        tick();
        idle(); #1;
        check("t3_spi_rdata", spi_rdata, 8'h3C);
        check("t3_cpu_unchanged", cpu_rdata, 8'h7D);
        tick();
        check("t3_cpu_rdata", cpu_rdata, 8'h7C);

        // CPU read of the buffered address is forwarded.
        idle(); spi_write(24'h000010, 8'h77); #1;
        tick();
        idle(); cpu_req(1'b0, 16'h0010, 8'h00); #1;
        check("t4_cpu_rdy", cpu_rdy, 1'b1);
        tick();
        idle(); #1;
        check("t4_wb_drain_addr", ram_addr, 16'h0010);
        tick();
        check("t4_cpu_fwd", cpu_rdata, 8'h77);
        check("t4_ram", ram_peek(16'h0010), 8'h77);

        // Out-of-range SPI read.
        idle(); spi_read(24'h010000); #1;
        check("t5_no_ram_en", ram_en, 1'b0);
        tick();
        idle(); #1;
        tick();
        check("t5_spi_ff", spi_rdata, 8'hFF);

        // Back-to-back SPI writes overrun the buffer.
        check("t6_overrun_pre", wb_overrun, 1'b0);
        idle(); spi_write(24'h000400, 8'hC1); #1;
        tick();
        idle(); spi_write(24'h000401, 8'hC2); #1;
        check("t6_retire_en_wr", {ram_en, ram_wr}, 2'b11);
        check("t6_retire_addr", ram_addr, 16'h0400);
        tick();
        check("t6_overrun", wb_overrun, 1'b1);
        idle(); #1;
        tick();
        check("t6_ram0", ram_peek(16'h0400), 8'hC1);
        check("t6_ram1", ram_peek(16'h0401), 8'hC2);

        // CPU write to the buffered address discards the buffered byte.
        idle(); spi_write(24'h000500, 8'hEE); #1;
        tick();
        idle(); cpu_req(1'b1, 16'h0500, 8'h33); #1;
        check("t7_cpu_rdy", cpu_rdy, 1'b1);
        tick();
        idle(); #1;
        check("t7_no_wb", ram_en, 1'b0);
        tick();
        check("t7_ram", ram_peek(16'h0500), 8'h33);

        // Reset with a pending buffered write.
        idle(); spi_write(24'h000600, 8'h99); #1;
        tick();
        idle();
        wr_snap = n_ram_wr;
        rst = 1'b1;
        #1;
        check("t8_ram_en", ram_en, 1'b0);
        check("t8_spi_rdata", spi_rdata, 8'h00);
        check("t8_cpu_rdata", cpu_rdata, 8'h00);
        check("t8_overrun", wb_overrun, 1'b0);
        check("t8_cpu_rdy", cpu_rdy, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t8_no_write", n_ram_wr, wr_snap);
        check("t8_ram", ram_peek(16'h0600), 8'h7C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
